// File: rtl/pll_drp_sequencer_if.sv
// Requester handshake and PLLE2 DRP bus, grouped for the reconfiguration
// sequencer. The master side is the sequencer (drives the DRP strobes and
// consumes configuration entries); the slave side is the environment
// (requester plus PLL DRP port).
interface pll_drp_sequencer_if;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [6:0]  cfg_addr;
  logic [15:0] cfg_mask;
  logic [15:0] cfg_data;
  logic        cfg_last;

  logic [6:0]  drp_daddr;
  logic [15:0] drp_di;
  logic [15:0] drp_do;
  logic        drp_den;
  logic        drp_dwe;
  logic        drp_drdy;

  modport master (
    input  cfg_valid, cfg_addr, cfg_mask, cfg_data, cfg_last, drp_do, drp_drdy,
    output cfg_ready, drp_daddr, drp_di, drp_den, drp_dwe
  );

  modport slave (
    output cfg_valid, cfg_addr, cfg_mask, cfg_data, cfg_last, drp_do, drp_drdy,
    input  cfg_ready, drp_daddr, drp_di, drp_den, drp_dwe
  );
endinterface

// File: rtl/pll_drp_sequencer.sv
// PLLE2_ADV DRP reconfiguration sequencer. Holds the PLL in reset, applies a
// batch of read-modify-write entries over DRP, releases reset and waits for
// the synchronized LOCKED. All timeouts share one saturating wait counter; a
// timeout fires when the counter equals its limit, and a DRDY/lock seen in
// that same cycle takes priority.
module pll_drp_sequencer #(
  parameter int RST_CYCLES   = 8,
  parameter int DRP_TIMEOUT  = 64,
  parameter int LOCK_TIMEOUT = 4096,
  parameter int CNT_W        = 13
) (
  input  logic                       clk,
  input  logic                       rst_n,
  pll_drp_sequencer_if.master        bus,
  output logic                       pll_rst,
  input  logic                       pll_locked,
  output logic                       busy,
  output logic                       done,
  output logic                       error,
  output logic                       locked_sync
);

  typedef enum logic [3:0] {
    IDLE, HOLD_RST, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, NEXT, RELEASE, WAIT_LOCK, ERR
  } state_t;

  // HOLD_RST leaves on the last of RST_CYCLES counted cycles (counter 0..N-1).
  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRP_LIM   = CNT_W'(DRP_TIMEOUT);
  localparam logic [CNT_W-1:0] LOCK_LIM  = CNT_W'(LOCK_TIMEOUT);

  state_t            state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic              lock_sync_p0, lock_sync_p1;
  logic              den_q, dwe_q, pll_rst_q, done_q, err_q;
  logic              den_d, dwe_d, pll_rst_d, done_d, err_d;
  logic [6:0]        daddr_q;
  logic [15:0]       di_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [15:0] rmw_merge(input logic [15:0] rd,
                                            input logic [15:0] mask,
                                            input logic [15:0] data);
    return (rd & mask) | (data & ~mask);
  endfunction

  // Next state, wait counter and next values of the registered outputs.
  always_comb begin
    state_d = state;
    cnt_d   = '0;
    done_d  = 1'b0;
    err_d   = err_q;
    case (state)
      IDLE: begin
        if (bus.cfg_valid) begin
          state_d = HOLD_RST;
          err_d   = 1'b0;
        end
      end
      HOLD_RST: begin
        if (cnt == RST_LAST) state_d = RD_REQ;
        else                 cnt_d   = sat_inc(cnt);
      end
      RD_REQ: state_d = RD_WAIT;
      RD_WAIT: begin
        if (bus.drp_drdy)        state_d = WR_REQ;
        else if (cnt == DRP_LIM) state_d = ERR;
        else                     cnt_d   = sat_inc(cnt);
      end
      WR_REQ: state_d = WR_WAIT;
      WR_WAIT: begin
        if (bus.drp_drdy)        state_d = bus.cfg_last ? RELEASE : NEXT;
        else if (cnt == DRP_LIM) state_d = ERR;
        else                     cnt_d   = sat_inc(cnt);
      end
      NEXT: begin
        if (bus.cfg_valid) state_d = RD_REQ;
      end
      RELEASE: state_d = WAIT_LOCK;
      WAIT_LOCK: begin
        if (locked_sync) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (cnt == LOCK_LIM) begin
          state_d = ERR;
        end else begin
          cnt_d = sat_inc(cnt);
        end
      end
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (state_d == ERR) err_d = 1'b1;
    den_d     = (state_d == RD_REQ) || (state_d == WR_REQ);
    dwe_d     = (state_d == WR_REQ);
    pll_rst_d = state_d inside {HOLD_RST, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, NEXT};
  end

  // State, counter and control outputs; a reset aborts any batch at once.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      den_q     <= 1'b0;
      dwe_q     <= 1'b0;
      pll_rst_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      den_q     <= den_d;
      dwe_q     <= dwe_d;
      pll_rst_q <= pll_rst_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // DRP address/data: address held from the read through the write of an
  // entry; write data merged straight from DO on the read's DRDY.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      daddr_q <= '0;
      di_q    <= '0;
    end else begin
      if (state_d == RD_REQ) daddr_q <= bus.cfg_addr;
      if (state == RD_WAIT && bus.drp_drdy)
        di_q <= rmw_merge(bus.drp_do, bus.cfg_mask, bus.cfg_data);
    end
  end

  // Two-flop synchronizer for the asynchronous PLL LOCKED pin.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lock_sync_p0 <= 1'b0;
      lock_sync_p1 <= 1'b0;
    end else begin
      lock_sync_p0 <= pll_locked;
      lock_sync_p1 <= lock_sync_p0;
    end
  end

  assign locked_sync   = lock_sync_p1;
  assign busy          = (state != IDLE);
  assign bus.cfg_ready = (state == WR_WAIT) && bus.drp_drdy;
  assign bus.drp_den   = den_q;
  assign bus.drp_dwe   = dwe_q;
  assign bus.drp_daddr = daddr_q;
  assign bus.drp_di    = di_q;
  assign pll_rst       = pll_rst_q;
  assign done          = done_q;
  assign error         = err_q;

endmodule

// File: tb/tb_pll_drp_sequencer.sv
// Directed bench for pll_drp_sequencer with a DRP responder model and a
// PLL lock model.
module tb_pll_drp_sequencer;
  localparam int RST_CYCLES   = 8;
  localparam int DRP_TIMEOUT  = 64;
  localparam int LOCK_TIMEOUT = 4096;

  logic clk = 1'b0;
  logic rst_n;
  logic pll_rst, busy, done, error, locked_sync;
  logic pll_locked = 1'b0;

  pll_drp_sequencer_if bus ();

  pll_drp_sequencer #(
    .RST_CYCLES(RST_CYCLES), .DRP_TIMEOUT(DRP_TIMEOUT),
    .LOCK_TIMEOUT(LOCK_TIMEOUT), .CNT_W(13)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .pll_rst(pll_rst),
    .pll_locked(pll_locked), .busy(busy), .done(done), .error(error),
    .locked_sync(locked_sync)
  );

  always #5 clk = ~clk;

  // DRP responder: DRDY drp_lat cycles after the DEN cycle (1 = next cycle).
  bit          drp_en = 1'b1;
  int          drp_lat = 2;
  logic [15:0] do_val = 16'hA5A5;
  int          pend = 0;
  assign bus.drp_do = do_val;

  always @(posedge clk) begin
    bus.drp_drdy <= 1'b0;
    if (!rst_n) pend <= 0;
    else if (bus.drp_den && drp_en) begin
      if (drp_lat <= 1) bus.drp_drdy <= 1'b1;
      else pend <= drp_lat - 1;
    end else if (pend > 0) begin
      pend <= pend - 1;
      if (pend == 1) bus.drp_drdy <= 1'b1;
    end
  end

  // PLL model: unlocked while in reset, locks lock_dly cycles after release.
  bit lock_en = 1'b1;
  int lock_dly = 5;
  int lk = 0;
  always @(posedge clk) begin
    if (!lock_en || pll_rst) begin
      pll_locked <= 1'b0;
      lk <= 0;
    end else if (!pll_locked) begin
      if (lk == lock_dly) pll_locked <= 1'b1;
      else lk <= lk + 1;
    end
  end

  // Entry table and feeder state.
  logic [6:0]  e_addr [0:3];
  logic [15:0] e_mask [0:3];
  logic [15:0] e_data [0:3];
  int n_ent, idx;
  bit gap, adv_pending;

  // Monitor state.
  int cyc, den_cnt, rd_cnt, wr_cnt, ready_cnt, done_cnt, rst_rises;
  int first_den_cyc, wr_den_cyc, rst_rise_cyc, rst_fall_cyc, lock_rise_cyc, done_cyc, err_rise_cyc;
  logic [6:0]  last_rd_addr, last_wr_addr;
  logic [15:0] wr_di_log [0:7];
  bit rst_gap, rst_after_ready, ready_prev;
  logic prev_rst = 1'b0, prev_lock = 1'b0, prev_err = 1'b0;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic load_entry(input int i);
    bus.cfg_addr  = e_addr[i];
    bus.cfg_mask  = e_mask[i];
    bus.cfg_data  = e_data[i];
    bus.cfg_last  = (i == n_ent - 1);
    bus.cfg_valid = 1'b1;
  endtask

  task automatic clr_mon();
    den_cnt = 0; rd_cnt = 0; wr_cnt = 0; ready_cnt = 0; done_cnt = 0; rst_rises = 0;
    first_den_cyc = -1; wr_den_cyc = -1; rst_rise_cyc = -1; rst_fall_cyc = -1;
    lock_rise_cyc = -1; done_cyc = -1; err_rise_cyc = -1;
    last_rd_addr = '0; last_wr_addr = '0;
    rst_gap = 1'b0; rst_after_ready = 1'b1; ready_prev = 1'b0;
    adv_pending = 1'b0;
  endtask

  task automatic start_batch(input int n);
    clr_mon();
    n_ent = n;
    idx = 0;
    load_entry(0);
  endtask

  // One clock: advance past the edge, update the feeder, then sample.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (adv_pending) begin
      adv_pending = 1'b0;
      idx++;
      if (idx < n_ent && !gap) load_entry(idx);
      else bus.cfg_valid = 1'b0;
    end
    if (bus.drp_den) begin
      den_cnt++;
      if (first_den_cyc < 0) first_den_cyc = cyc;
      if (bus.drp_dwe) begin
        if (wr_cnt < 8) wr_di_log[wr_cnt] = bus.drp_di;
        wr_cnt++;
        last_wr_addr = bus.drp_daddr;
        if (wr_den_cyc < 0) wr_den_cyc = cyc;
      end else begin
        rd_cnt++;
        last_rd_addr = bus.drp_daddr;
      end
    end
    if (pll_rst && !prev_rst) begin
      rst_rises++;
      if (rst_rise_cyc < 0) rst_rise_cyc = cyc;
    end
    if (!pll_rst && prev_rst) rst_fall_cyc = cyc;
    if (ready_prev) rst_after_ready = pll_rst;
    ready_prev = bus.cfg_ready;
    if (bus.cfg_ready) begin
      ready_cnt++;
      adv_pending = 1'b1;
      if (!pll_rst) rst_gap = 1'b1;
    end
    if (pll_locked && !prev_lock) lock_rise_cyc = cyc;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (error && !prev_err) begin
      err_rise_cyc = cyc;
      bus.cfg_valid = 1'b0;
    end
    prev_rst = pll_rst;
    prev_lock = pll_locked;
    prev_err = error;
  endtask

  task automatic run(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      tick();
      if (done || error) ok = 1'b1;
    end
  endtask

  bit ok;

  initial begin
    rst_n = 1'b0;
    bus.cfg_valid = 1'b0;
    bus.cfg_addr = '0; bus.cfg_mask = '0; bus.cfg_data = '0; bus.cfg_last = 1'b0;
    gap = 1'b0; n_ent = 0; idx = 0; cyc = 0;
    clr_mon();

    // Reset state
    repeat (3) tick();
    check("rst_den", bus.drp_den, 0);
    check("rst_dwe", bus.drp_dwe, 0);
    check("rst_daddr", bus.drp_daddr, 0);
    check("rst_di", bus.drp_di, 0);
    check("rst_cfg_ready", bus.cfg_ready, 0);
    check("rst_pll_rst", pll_rst, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_locked_sync", locked_sync, 0);
    rst_n = 1'b1;
    repeat (12) tick();
    check("idle_locked_sync", locked_sync, 1);

    // Single entry, 2-cycle DRDY latency, DO=A5A5 -> DI=(A5A5&F000)|(0123&0FFF)=A123
    e_addr[0] = 7'h08; e_mask[0] = 16'hF000; e_data[0] = 16'h0123;
    drp_lat = 2; do_val = 16'hA5A5;
    start_batch(1);
    run(300, ok);
    check("t1_finished", ok, 1);
    check("t1_rd_cnt", rd_cnt, 1);
    check("t1_wr_cnt", wr_cnt, 1);
    check("t1_rd_addr", last_rd_addr, 7'h08);
    check("t1_wr_addr", last_wr_addr, 7'h08);
    check("t1_wr_di", wr_di_log[0], 16'hA123);
    check("t1_rst_to_den", first_den_cyc - rst_rise_cyc, RST_CYCLES);
    check("t1_lock_to_done", done_cyc - lock_rise_cyc, 3);
    check("t1_done_cnt", done_cnt, 1);
    check("t1_error", error, 0);
    check("t1_busy_after", busy, 0);
    check("t1_locked_sync", locked_sync, 1);

    // Three-entry batch
    e_addr[1] = 7'h09; e_mask[1] = 16'h0F0F; e_data[1] = 16'h5050;
    e_addr[2] = 7'h14; e_mask[2] = 16'h00FF; e_data[2] = 16'h3C00;
    tick();
    start_batch(3);
    run(400, ok);
    check("t2_finished", ok, 1);
    check("t2_ready_cnt", ready_cnt, 3);
    check("t2_den_cnt", den_cnt, 6);
    check("t2_rst_rises", rst_rises, 1);
    check("t2_rst_gap", rst_gap, 0);
    check("t2_rst_after_last", rst_after_ready, 0);
    check("t2_di0", wr_di_log[0], 16'hA123);
    check("t2_di1", wr_di_log[1], 16'h5555);
    check("t2_di2", wr_di_log[2], 16'h3CA5);
    check("t2_last_addr", last_wr_addr, 7'h14);
    check("t2_done_cnt", done_cnt, 1);

    // Immediate DRDY, DO=FFFF, mask 0 -> DI is data
    e_addr[0] = 7'h0A; e_mask[0] = 16'h0000; e_data[0] = 16'h1234;
    drp_lat = 1; do_val = 16'hFFFF;
    tick();
    start_batch(1);
    run(300, ok);
    check("t6_finished", ok, 1);
    check("t6_wr_di", wr_di_log[0], 16'h1234);
    check("t6_wrreq_cycle", wr_den_cyc - first_den_cyc, 2);
    check("t6_done_cnt", done_cnt, 1);

    // DRDY never: RD_REQ at c, RD_WAIT c+1..c+65 (counter 0..64), ERR at c+66
    drp_en = 1'b0;
    e_addr[0] = 7'h08; e_mask[0] = 16'hF000; e_data[0] = 16'h0123;
    tick();
    start_batch(1);
    run(400, ok);
    check("t3_finished", ok, 1);
    check("t3_err_delay", err_rise_cyc - first_den_cyc, DRP_TIMEOUT + 2);
    tick();
    check("t3_pll_rst_after", pll_rst, 0);
    check("t3_busy_after", busy, 0);
    check("t3_error_sticky", error, 1);
    check("t3_done_cnt", done_cnt, 0);
    check("t3_den_cnt", den_cnt, 1);

    // LOCKED held low: RELEASE at r, WAIT_LOCK r+1..r+4097, ERR at r+4098
    drp_en = 1'b1; drp_lat = 1; lock_en = 1'b0;
    start_batch(1);
    run(4600, ok);
    check("t4_finished", ok, 1);
    check("t4_err_delay", err_rise_cyc - rst_fall_cyc, LOCK_TIMEOUT + 2);
    check("t4_wr_cnt", wr_cnt, 1);
    check("t4_done_cnt", done_cnt, 0);
    tick();
    check("t4_error_idle", error, 1);
    lock_en = 1'b1;
    start_batch(1);
    tick();
    check("t4_error_cleared", error, 0);
    check("t4_busy_new", busy, 1);
    check("t4_pll_rst_new", pll_rst, 1);
    run(300, ok);
    check("t4_new_done", done_cnt, 1);
    check("t4_new_error", error, 0);

    // Reset while waiting in NEXT between entries
    gap = 1'b1;
    e_addr[1] = 7'h09; e_mask[1] = 16'h0F0F; e_data[1] = 16'h5050;
    drp_lat = 2; do_val = 16'hA5A5;
    tick();
    start_batch(2);
    for (int i = 0; i < 100 && ready_cnt == 0; i++) tick();
    check("t5_first_ready", ready_cnt, 1);
    repeat (3) tick();
    check("t5_next_busy", busy, 1);
    check("t5_next_pll_rst", pll_rst, 1);
    check("t5_next_den", bus.drp_den, 0);
    rst_n = 1'b0;
    tick();
    check("t5_rst_pll_rst", pll_rst, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_daddr", bus.drp_daddr, 0);
    check("t5_rst_di", bus.drp_di, 0);
    check("t5_rst_den", bus.drp_den, 0);
    check("t5_rst_error", error, 0);
    check("t5_rst_locked_sync", locked_sync, 0);
    rst_n = 1'b1;
    gap = 1'b0;
    repeat (2) tick();
    start_batch(1);
    run(300, ok);
    check("t5_rerun_finished", ok, 1);
    check("t5_rerun_done", done_cnt, 1);
    check("t5_rerun_error", error, 0);
    check("t5_rerun_rd_cnt", rd_cnt, 1);
    check("t5_rerun_di", wr_di_log[0], 16'hA123);
    check("t5_rerun_rst_to_den", first_den_cyc - rst_rise_cyc, RST_CYCLES);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
